// File: rtl/lcd_capture.sv
// Rebuilds the PPU's serial 2-bpp LCD stream into a byte-packed framebuffer, four pixels per byte.
// Define LCD_CAPTURE_DBUF_EN to alternate frames between two RAM banks.
module lcd_capture #(
    parameter int unsigned WIDTH  = 160,
    parameter int unsigned HEIGHT = 144,
    parameter int unsigned AW     = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vsync,
    input  logic          hsync,
    input  logic          pix_valid,
    input  logic [1:0]    pix_color,
    input  logic          err_clr,
    output logic          fb_we,
    output logic [AW:0]   fb_addr,
    output logic [7:0]    fb_data,
    output logic          frame_done,
    output logic          front_bank,
    output logic          synced,
    output logic          err_overrun,
    output logic          err_short
);

    localparam int unsigned XW = $clog2(WIDTH + 1);
    localparam int unsigned YW = $clog2(HEIGHT + 1);

    localparam logic [XW-1:0] XMax     = XW'(WIDTH);
    localparam logic [XW-1:0] XLast    = XW'(WIDTH - 1);
    localparam logic [YW-1:0] YMax     = YW'(HEIGHT);
    localparam logic [YW-1:0] YLast    = YW'(HEIGHT - 1);
    localparam logic [AW-1:0] LineStep = AW'(WIDTH / 4);

    localparam logic [1:0] StUnsync = 2'd0;
    localparam logic [1:0] StActive = 2'd1;
    localparam logic [1:0] StDone   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [1:0]    g_q, g_d;
    logic [5:0]    acc_q, acc_d;
    logic [AW-1:0] base_q, base_d;
    logic          we_q, we_d;
    logic [AW:0]   addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic          done_q, done_d;
    logic          front_q, front_d;
    logic          synced_q, synced_d;
    logic          ovr_q, ovr_d;
    logic          short_q, short_d;
    logic          ovr_set, short_set;
    logic          bank;

`ifdef LCD_CAPTURE_DBUF_EN
    assign bank = ~front_q;
`else
    assign bank = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        g_d       = g_q;
        acc_d     = acc_q;
        base_d    = base_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        done_d    = 1'b0;
        front_d   = front_q;
        synced_d  = synced_q;
        ovr_set   = 1'b0;
        short_set = 1'b0;

        // Line/frame events resolve first so a coincident pixel lands in the new position.
        if (vsync) begin
            state_d  = StActive;
            x_d      = '0;
            y_d      = '0;
            g_d      = '0;
            acc_d    = '0;
            base_d   = '0;
            synced_d = 1'b1;
        end else if (state_q == StActive && hsync) begin
            if (x_q != XMax) begin
                short_set = 1'b1;
                if (g_q != 2'd0) begin
                    // Unfilled slots are already zero in acc.
                    we_d   = 1'b1;
                    addr_d = {bank, base_q + AW'(x_q >> 2)};
                    data_d = {2'b00, acc_q};
                end
            end
            x_d    = '0;
            g_d    = '0;
            acc_d  = '0;
            base_d = base_q + LineStep;
            if (y_q != YMax) begin
                y_d = y_q + 1'b1;
            end
            if (y_q == YLast) begin
                state_d = StDone;
            end
        end

        if (pix_valid) begin
            if (state_d == StActive && x_d != XMax && y_d != YMax) begin
                if (g_d == 2'd3) begin
                    we_d   = 1'b1;
                    addr_d = {bank, base_d + AW'(x_d >> 2)};
                    data_d = {pix_color, acc_d};
                    acc_d  = '0;
                    if (x_d == XLast && y_d == YLast) begin
                        done_d = 1'b1;
`ifdef LCD_CAPTURE_DBUF_EN
                        front_d = ~front_q;
`endif
                    end
                end else begin
                    acc_d[2*g_d +: 2] = pix_color;
                end
                x_d = x_d + 1'b1;
                g_d = g_d + 1'b1;
            end else if (state_d != StUnsync) begin
                ovr_set = 1'b1;
            end
        end

        ovr_d   = ovr_set | (ovr_q & ~err_clr);
        short_d = short_set | (short_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StUnsync;
            x_q      <= '0;
            y_q      <= '0;
            g_q      <= '0;
            acc_q    <= '0;
            base_q   <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            front_q  <= 1'b0;
            synced_q <= 1'b0;
            ovr_q    <= 1'b0;
            short_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            g_q      <= g_d;
            acc_q    <= acc_d;
            base_q   <= base_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            done_q   <= done_d;
            front_q  <= front_d;
            synced_q <= synced_d;
            ovr_q    <= ovr_d;
            short_q  <= short_d;
        end
    end

    assign fb_we       = we_q;
    assign fb_addr     = addr_q;
    assign fb_data     = data_q;
    assign frame_done  = done_q;
    assign front_bank  = front_q;
    assign synced      = synced_q;
    assign err_overrun = ovr_q;
    assign err_short   = short_q;

endmodule

// File: tb/tb_lcd_capture.sv
// Bench for lcd_capture: directed frame/line scenarios with random shades, checked against a
// line-level model of the expected byte writes and error flags.
module tb_lcd_capture;

    localparam int W  = 160;
    localparam int H  = 144;
    localparam int AW = 13;

    typedef int iarr_t[];
    typedef struct packed {
        logic          done;
        logic [AW:0]   addr;
        logic [7:0]    data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          vsync = 1'b0;
    logic          hsync = 1'b0;
    logic          pix_valid = 1'b0;
    logic [1:0]    pix_color = 2'd0;
    logic          err_clr = 1'b0;
    logic          fb_we;
    logic [AW:0]   fb_addr;
    logic [7:0]    fb_data;
    logic          frame_done;
    logic          front_bank;
    logic          synced;
    logic          err_overrun;
    logic          err_short;

    int  checks = 0;
    int  errors = 0;
    int  done_cnt = 0;
    int  wr_cnt = 0;
    bit  exp_front = 1'b0;
    bit  exp_ovr = 1'b0;
    bit  exp_short = 1'b0;
    wr_t got[$];
    wr_t expq[$];

    lcd_capture #(.WIDTH(W), .HEIGHT(H), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .vsync      (vsync),
        .hsync      (hsync),
        .pix_valid  (pix_valid),
        .pix_color  (pix_color),
        .err_clr    (err_clr),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .frame_done (frame_done),
        .front_bank (front_bank),
        .synced     (synced),
        .err_overrun(err_overrun),
        .err_short  (err_short)
    );

    always #5 clk = ~clk;

    // Capture every registered write just after the edge that produced it.
    always @(posedge clk) begin
        #1;
        if (fb_we === 1'b1) begin
            got.push_back({frame_done, fb_addr, fb_data});
            wr_cnt++;
        end
        if (frame_done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit v, input bit h, input bit p, input logic [1:0] c,
                        input bit clr);
        vsync = v; hsync = h; pix_valid = p; pix_color = c; err_clr = clr;
        @(negedge clk);
        vsync = 1'b0; hsync = 1'b0; pix_valid = 1'b0; err_clr = 1'b0;
    endtask

    function automatic bit exp_bank();
`ifdef LCD_CAPTURE_DBUF_EN
        return ~exp_front;
`else
        return 1'b0;
`endif
    endfunction

    function automatic iarr_t mk_cols(input int n, input int mode);
        iarr_t c = new[n];
        for (int i = 0; i < n; i++) begin
            case (mode)
                0:       c[i] = i % 4;
                1:       c[i] = int'($urandom_range(0, 3));
                default: c[i] = 3;
            endcase
        end
        return c;
    endfunction

    // Byte k of a line: pixels 4k..4k+3, shade n in bits [2n+1:2n], absent pixels read as 0.
    function automatic logic [7:0] pack(input iarr_t c, input int k);
        logic [7:0] b = 8'h00;
        for (int n = 0; n < 4; n++) begin
            if (4 * k + n < c.size() && 4 * k + n < W) b[2*n +: 2] = 2'(c[4 * k + n]);
        end
        return b;
    endfunction

    task automatic model_line(input int y, input iarr_t c, input bit trail);
        int n = c.size();
        int vis = (n < W) ? n : W;
        wr_t w;
        for (int k = 0; k < vis / 4; k++) begin
            w.done = (y == H - 1 && k == W / 4 - 1);
            w.addr = {exp_bank(), AW'(y * (W / 4) + k)};
            w.data = pack(c, k);
            expq.push_back(w);
`ifdef LCD_CAPTURE_DBUF_EN
            if (w.done) exp_front = ~exp_front;
`endif
        end
        if (n > W) exp_ovr = 1'b1;
        if (trail) begin
            if (vis != W) exp_short = 1'b1;
            if (n < W && n % 4 != 0) begin
                w.done = 1'b0;
                w.addr = {exp_bank(), AW'(y * (W / 4) + n / 4)};
                w.data = pack(c, n / 4);
                expq.push_back(w);
            end
        end
    endtask

    task automatic check_writes(input string tag);
        wr_t e;
        while (expq.size() > 0) begin
            e = expq.pop_front();
            if (got.size() == 0) begin
                chk({tag, "_present"}, 32'(0), 32'(1));
            end else begin
                chk(tag, 32'(got.pop_front()), 32'(e));
            end
        end
        chk({tag, "_extra"}, 32'(got.size()), 32'(0));
        got.delete();
    endtask

    // lead: 0 none, 1 first pixel with hsync, 2 first pixel with vsync.
    task automatic send_line(input int y, input iarr_t c, input int lead, input bit trail,
                             input bit gaps);
        for (int i = 0; i < c.size(); i++) begin
            if (i == 0 && lead == 1) begin
                step(1'b0, 1'b1, 1'b1, 2'(c[i]), 1'b0);
            end else if (i == 0 && lead == 2) begin
                step(1'b1, 1'b0, 1'b1, 2'(c[i]), 1'b0);
            end else begin
                if (gaps && $urandom_range(0, 7) == 0) step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
                step(1'b0, 1'b0, 1'b1, 2'(c[i]), 1'b0);
            end
        end
        if (trail) step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
        model_line(y, c, trail);
        check_writes($sformatf("wr_y%0d", y));
    endtask

    initial begin
        #12;
        chk("rst_we", 32'(fb_we), 32'(0));
        chk("rst_addr", 32'(fb_addr), 32'(0));
        chk("rst_data", 32'(fb_data), 32'(0));
        chk("rst_done", 32'(frame_done), 32'(0));
        chk("rst_front", 32'(front_bank), 32'(0));
        chk("rst_synced", 32'(synced), 32'(0));
        chk("rst_ovr", 32'(err_overrun), 32'(0));
        chk("rst_short", 32'(err_short), 32'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Strobes and hsync before any vsync are ignored.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 2'($urandom_range(0, 3)), 1'b0);
        step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
        chk("unsync_nowrite", 32'(got.size()), 32'(0));
        chk("unsync_synced", 32'(synced), 32'(0));
        chk("unsync_short", 32'(err_short), 32'(0));

        // Full frame of shade x%4.
        step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        chk("vsync_synced", 32'(synced), 32'(1));
        for (int y = 0; y < H; y++) send_line(y, mk_cols(W, 0), 0, 1'b1, 1'b0);
        chk("f1_done_cnt", 32'(done_cnt), 32'(1));
        chk("f1_wr_cnt", 32'(wr_cnt), 32'(W * H / 4));
        chk("f1_front", 32'(front_bank), 32'(exp_front));
        chk("f1_short", 32'(err_short), 32'(0));
        chk("f1_ovr", 32'(err_overrun), 32'(0));

        // After the frame: hsync ignored, pixels overrun, error beats a coincident clear.
        step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
        chk("done_hsync_nowrite", 32'(got.size()), 32'(0));
        chk("done_hsync_short", 32'(err_short), 32'(0));
        step(1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
        exp_ovr = 1'b1;
        chk("done_pix_ovr", 32'(err_overrun), 32'(exp_ovr));
        chk("done_pix_nowrite", 32'(got.size()), 32'(0));
        step(1'b0, 1'b0, 1'b1, 2'd2, 1'b1);
        chk("clr_vs_new_err", 32'(err_overrun), 32'(1));
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        exp_ovr = 1'b0;
        exp_short = 1'b0;
        chk("clr_ovr", 32'(err_overrun), 32'(exp_ovr));

        // Short line of six shade-3 pixels, then an overlong line.
        step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        send_line(0, mk_cols(6, 2), 0, 1'b1, 1'b0);
        chk("short_flag", 32'(err_short), 32'(exp_short));
        send_line(1, mk_cols(W + 1, 1), 0, 1'b1, 1'b0);
        chk("overrun_flag", 32'(err_overrun), 32'(exp_ovr));
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        exp_ovr = 1'b0;
        exp_short = 1'b0;
        chk("clr2_ovr", 32'(err_overrun), 32'(0));
        chk("clr2_short", 32'(err_short), 32'(0));

        // Line 2 ends with an hsync that carries line 3's first pixel.
        send_line(2, mk_cols(W, 1), 0, 1'b0, 1'b1);
        send_line(3, mk_cols(3, 1), 1, 1'b1, 1'b0);
        for (int y = 4; y < 70; y++) send_line(y, mk_cols(W, 1), 0, 1'b1, 1'b1);
        send_line(70, mk_cols(50, 1), 0, 1'b0, 1'b1);

        // Restart mid-frame; the vsync carries pixel (0,0) of the new frame.
        for (int y = 0; y < H; y++) send_line(y, mk_cols(W, 1), (y == 0) ? 2 : 0, 1'b1, y % 8 == 0);
        chk("f3_done_cnt", 32'(done_cnt), 32'(2));
        chk("f3_front", 32'(front_bank), 32'(exp_front));
        chk("f3_short", 32'(err_short), 32'(exp_short));
        chk("f3_ovr", 32'(err_overrun), 32'(exp_ovr));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
